// File: rtl/rgmii_phy_if.sv
// MAC-side RGMII interface: converts the 4-bit DDR PHY buses to and from 8-bit
// single-rate data, clocked entirely by RGMII_RX_CLK. MDIO is left unimplemented.

module rgmii_oddr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] d0_q, d0_d;
    logic [WIDTH-1:0] d1_q, d1_d;
    logic [WIDTH-1:0] d1_fall_q, d1_fall_d;

    always_comb begin
        d0_d      = rst_n ? d0 : '0;
        d1_d      = rst_n ? d1 : '0;
        d1_fall_d = d1_q;
    end

    always_ff @(posedge clk) begin
        d0_q <= d0_d;
        d1_q <= d1_d;
    end

    // Second-phase data is retimed onto the falling edge so the output mux never
    // switches data and select at the same instant, matching ODDRX1F behaviour.
    always_ff @(negedge clk) begin
        d1_fall_q <= d1_fall_d;
    end

    assign q = clk ? d0_q : d1_fall_q;
endmodule

module rgmii_phy_if (
    input  logic       RGMII_RX_CLK,
    input  logic       RESET_N,
    output logic [7:0] RX_DATA,
    output logic       RX_DV,
    input  logic [7:0] TX_DATA,
    input  logic       TX_DV,
    input  logic       RGMII_RX_CTL,
    input  logic [3:0] RGMII_RX_D,
    output logic       RGMII_TX_CLK,
    output logic       RGMII_TX_CTL,
    output logic [3:0] RGMII_TX_D,
    input  logic       MDIO_CLK,
    inout  wire        MDIO_DATA
);
    logic [3:0] lo_q, lo_d;
    logic       ctl_q, ctl_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_dv_q, rx_dv_d;
    logic       unused_mdio_clk;

    always_comb begin
        lo_d      = RESET_N ? RGMII_RX_D : 4'h0;
        ctl_d     = RESET_N & RGMII_RX_CTL;
        rx_data_d = RESET_N ? {RGMII_RX_D, lo_q} : 8'h00;
        rx_dv_d   = RESET_N & ctl_q;
    end

    // The falling edge captures the first nibble and the RX_DV half of RX_CTL;
    // the second half of RX_CTL (RX_DV xor RX_ER) is deliberately ignored.
    always_ff @(negedge RGMII_RX_CLK) begin
        lo_q  <= lo_d;
        ctl_q <= ctl_d;
    end

    always_ff @(posedge RGMII_RX_CLK) begin
        rx_data_q <= rx_data_d;
        rx_dv_q   <= rx_dv_d;
    end

    assign RX_DATA = rx_data_q;
    assign RX_DV   = rx_dv_q;

    rgmii_oddr #(.WIDTH(4)) u_tx_d (
        .clk   (RGMII_RX_CLK),
        .rst_n (RESET_N),
        .d0    (TX_DATA[3:0]),
        .d1    (TX_DATA[7:4]),
        .q     (RGMII_TX_D)
    );

    rgmii_oddr #(.WIDTH(1)) u_tx_ctl (
        .clk   (RGMII_RX_CLK),
        .rst_n (RESET_N),
        .d0    (TX_DV),
        .d1    (TX_DV),
        .q     (RGMII_TX_CTL)
    );

    // Forwarded clock uses the same output register path as the data; never reset
    // so the PHY keeps seeing a clock during reset.
    rgmii_oddr #(.WIDTH(1)) u_tx_clk (
        .clk   (RGMII_RX_CLK),
        .rst_n (1'b1),
        .d0    (1'b1),
        .d1    (1'b0),
        .q     (RGMII_TX_CLK)
    );

    assign MDIO_DATA       = 1'bz;
    assign unused_mdio_clk = MDIO_CLK;
endmodule

// File: tb/tb_rgmii_phy_if.sv
// Scoreboard bench for rgmii_phy_if: a per-cycle byte-level model predicts RX and TX
// wire contents; a monitor checks both clock phases against the queued predictions.

module tb_rgmii_phy_if;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic [7:0] tx_data = 8'h00;
    logic       tx_dv = 1'b0;
    logic       rx_ctl = 1'b0;
    logic [3:0] rx_d = 4'h0;
    logic       tx_clk;
    logic       tx_ctl;
    logic [3:0] tx_d;
    logic       mdio_clk = 1'b0;
    wire        mdio_data;
    logic       tb_mdio_en = 1'b0;
    logic       tb_mdio_val = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // rx/tx hold {valid, byte}; due is the rising-edge index where the result is visible
    typedef struct {
        int         due;
        logic [8:0] rx;
        logic [8:0] tx;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] model_rx_prev = 9'h0;

    always #4 clk = ~clk;
    always #40 mdio_clk = ~mdio_clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mdio_data = tb_mdio_en ? tb_mdio_val : 1'bz;

    rgmii_phy_if dut (
        .RGMII_RX_CLK (clk),
        .RESET_N      (reset_n),
        .RX_DATA      (rx_data),
        .RX_DV        (rx_dv),
        .TX_DATA      (tx_data),
        .TX_DV        (tx_dv),
        .RGMII_RX_CTL (rx_ctl),
        .RGMII_RX_D   (rx_d),
        .RGMII_TX_CLK (tx_clk),
        .RGMII_TX_CTL (tx_ctl),
        .RGMII_TX_D   (tx_d),
        .MDIO_CLK     (mdio_clk),
        .MDIO_DATA    (mdio_data)
    );

    function automatic void check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // One cycle on the wire: low nibble after the rising edge, high nibble after the falling edge.
    task automatic apply_stimulus(input logic rst_n, input logic [7:0] rx_byte, input logic rx_valid,
                                  input logic [7:0] tx_byte, input logic tx_valid, input logic loopback);
        exp_t e;
        logic [8:0] tx_model;
        @(posedge clk);
        #1;
        if (loopback) begin
            tx_data  = rx_data;
            tx_dv    = rx_dv;
            tx_model = model_rx_prev;
        end else begin
            tx_data  = tx_byte;
            tx_dv    = tx_valid;
            tx_model = {tx_valid, tx_byte};
        end
        reset_n = rst_n;
        rx_d    = rx_byte[3:0];
        rx_ctl  = rx_valid;
        e.due   = cyc + 1;
        e.rx    = rst_n ? {rx_valid, rx_byte} : 9'h0;
        e.tx    = rst_n ? tx_model : 9'h0;
        sb_q.push_back(e);
        model_rx_prev = e.rx;
        @(negedge clk);
        #1;
        rx_d   = rx_byte[7:4];
        rx_ctl = 1'($urandom_range(0, 1));
    endtask

    initial begin : monitor_rise
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q[0];
                check_output("rx_byte", {rx_dv, rx_data}, e.rx);
                check_output("tx_lo_phase", {4'h0, tx_ctl, tx_d}, {4'h0, e.tx[8], e.tx[3:0]});
                check_output("tx_clk_high", {8'h0, tx_clk}, 9'h001);
            end
        end
    end

    initial begin : monitor_fall
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                check_output("tx_hi_phase", {4'h0, tx_ctl, tx_d}, {4'h0, e.tx[8], e.tx[7:4]});
                check_output("tx_clk_low", {8'h0, tx_clk}, 9'h000);
            end
        end
    end

    initial begin : mdio_probe
        logic v;
        repeat (8) begin
            repeat (10) @(posedge clk);
            #3;
            v = 1'($urandom_range(0, 1));
            tb_mdio_val = v;
            tb_mdio_en  = 1'b1;
            #1;
            check_output("mdio_released", {8'h0, mdio_data}, {8'h0, v});
            tb_mdio_en = 1'b0;
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int left;
        // Reset held with RX_CTL and TX_DV active
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 8'($urandom), 1'(i % 2), 8'($urandom), 1'b1, 1'b0);
        // Single received byte
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
        // Loopback with gaps
        apply_stimulus(1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'hB6, 1'b1, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'hC7, 1'b1, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
        // TX idle with all-ones data
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        // Reset during the second of three back-to-back bytes
        apply_stimulus(1'b1, 8'h11, 1'b1, 8'h81, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h22, 1'b1, 8'h82, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b1, 8'h83, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0, 8'h84, 1'b0, 1'b0);
        // Randomized traffic with occasional resets and loopback cycles
        for (int i = 0; i < 200; i++)
            apply_stimulus(1'($urandom_range(0, 19) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                           8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        left = sb_q.size();
        check_output("scoreboard_drained", 9'(left), 9'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
